// File: rtl/mult_div_unit.sv
// RV32M multiply/divide unit: single-cycle 33x33 multiply, 32-step restoring
// divide, two-cycle result finalisation and a valid/ready writeback handshake.
module mult_div_unit #(
  parameter int unsigned IdxWidth = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                mdu_valid,
  input  logic [2:0]          operation,
  input  logic [31:0]         operand_a,
  input  logic [31:0]         operand_b,
  input  logic [IdxWidth-1:0] idx,
  output logic                mdu_ready,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [31:0]         result,
  output logic [IdxWidth-1:0] result_idx
);

  localparam int unsigned XLen   = 32;
  localparam int unsigned CntW   = 5;
  localparam int unsigned ProdW  = 2 * XLen;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e              state_q, state_d;
  logic                mdu_ready_q, mdu_ready_d;
  logic                result_valid_q, result_valid_d;
  logic [XLen-1:0]     result_q, result_d;
  logic [IdxWidth-1:0] result_idx_q, result_idx_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  // quo_q doubles as multiplicand / dividend-then-quotient; dvs_q as multiplier / divisor
  logic [XLen-1:0]     quo_q, quo_d;
  logic [XLen-1:0]     rem_q, rem_d;
  logic [XLen-1:0]     dvs_q, dvs_d;
  logic [XLen-1:0]     pre_q, pre_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ext_a_q, ext_a_d;
  logic                ext_b_q, ext_b_d;
  logic                mul_hi_q, mul_hi_d;
  logic                is_rem_q, is_rem_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  // 0: sign fix-up pending, 1: staged result ready to present
  logic                phase_q, phase_d;

  // Datapath helpers
  logic [ProdW-1:0] prod;
  logic [XLen:0]    rem_sh;
  logic [XLen-1:0]  diff;
  logic             ge;
  logic             sgn_div, a_neg, b_neg;
  logic [XLen-1:0]  a_mag, b_mag;

  // Next-state, datapath and output computation
  always_comb begin
    state_d        = state_q;
    result_valid_d = result_valid_q;
    result_d       = result_q;
    result_idx_d   = result_idx_q;
    idx_d          = idx_q;
    quo_d          = quo_q;
    rem_d          = rem_q;
    dvs_d          = dvs_q;
    pre_d          = pre_q;
    cnt_d          = cnt_q;
    ext_a_d        = ext_a_q;
    ext_b_d        = ext_b_q;
    mul_hi_d       = mul_hi_q;
    is_rem_d       = is_rem_q;
    neg_quo_d      = neg_quo_q;
    neg_rem_d      = neg_rem_q;
    phase_d        = phase_q;

    prod    = ProdW'($signed({ext_a_q, quo_q})) * ProdW'($signed({ext_b_q, dvs_q}));
    rem_sh  = {rem_q, quo_q[XLen-1]};
    ge      = rem_sh >= {1'b0, dvs_q};
    diff    = rem_sh[XLen-1:0] - dvs_q;

    sgn_div = ~operation[0];
    a_neg   = sgn_div & operand_a[XLen-1];
    b_neg   = sgn_div & operand_b[XLen-1];
    a_mag   = a_neg ? XLen'(-operand_a) : operand_a;
    b_mag   = b_neg ? XLen'(-operand_b) : operand_b;

    if (flush) begin
      state_d        = IDLE;
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_valid) begin
            idx_d = idx;
            if (!operation[2]) begin
              ext_a_d  = (operation != 3'd3) & operand_a[XLen-1];
              ext_b_d  = ~operation[1] & operand_b[XLen-1];
              mul_hi_d = operation[1:0] != 2'd0;
              quo_d    = operand_a;
              dvs_d    = operand_b;
              state_d  = MUL;
            end else begin
              is_rem_d = operation[1];
              cnt_d    = '0;
              phase_d  = 1'b0;
              rem_d    = '0;
              if (operand_b == '0) begin
                quo_d     = '1;
                rem_d     = operand_a;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = DONE;
              end else if (sgn_div && operand_a == 32'h8000_0000 &&
                           operand_b == 32'hFFFF_FFFF) begin
                quo_d     = 32'h8000_0000;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = DONE;
              end else begin
                quo_d     = a_mag;
                dvs_d     = b_mag;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                state_d   = DIV;
              end
            end
          end
        end
        MUL: begin
          pre_d   = mul_hi_q ? prod[ProdW-1:XLen] : prod[XLen-1:0];
          phase_d = 1'b1;
          state_d = DONE;
        end
        DIV: begin
          quo_d = {quo_q[XLen-2:0], ge};
          rem_d = ge ? diff : rem_sh[XLen-1:0];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(31)) begin
            phase_d = 1'b0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (!result_valid_q) begin
            if (!phase_q) begin
              if (is_rem_q) pre_d = neg_rem_q ? XLen'(-rem_q) : rem_q;
              else          pre_d = neg_quo_q ? XLen'(-quo_q) : quo_q;
              phase_d = 1'b1;
            end else begin
              result_d       = pre_q;
              result_idx_d   = idx_q;
              result_valid_d = 1'b1;
            end
          end else if (result_ready) begin
            result_valid_d = 1'b0;
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    mdu_ready_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      mdu_ready_q    <= 1'b1;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_idx_q   <= '0;
      idx_q          <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      dvs_q          <= '0;
      pre_q          <= '0;
      cnt_q          <= '0;
      ext_a_q        <= 1'b0;
      ext_b_q        <= 1'b0;
      mul_hi_q       <= 1'b0;
      is_rem_q       <= 1'b0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      phase_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      mdu_ready_q    <= mdu_ready_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_idx_q   <= result_idx_d;
      idx_q          <= idx_d;
      quo_q          <= quo_d;
      rem_q          <= rem_d;
      dvs_q          <= dvs_d;
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      ext_a_q        <= ext_a_d;
      ext_b_q        <= ext_b_d;
      mul_hi_q       <= mul_hi_d;
      is_rem_q       <= is_rem_d;
      neg_quo_q      <= neg_quo_d;
      neg_rem_q      <= neg_rem_d;
      phase_q        <= phase_d;
    end
  end

  assign mdu_ready    = mdu_ready_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign result_idx   = result_idx_q;

endmodule
